multicycle_seq: RTL and testbench
=================================

Name: multicycle_seq

Overview:
Multicycle sequencing FSM for the RV32I core. It steps one instruction at a time through IDLE/FETCH/DECODE/EXEC/MEM/WB and drives the datapath write-enables and muxes. It consumes the combinational decoder's flags plus the raw opcode, and owns the single shared memory port handshake, including a wait-state timeout. It also keeps a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, max cycles mem_req may stay high without mem_ready before FAULT (>=2)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
run  in  1  permit starting a new instruction
opcode  in  7  IR[6:0]
branch  in  1  decoder Branch
mem_read  in  1  decoder MemRead
mem_write  in  1  decoder MemWrite
reg_write  in  1  decoder RegWrite
branch_taken  in  1  comparator result, valid in EXEC
mem_ready  in  1  memory completes current request this cycle
mem_req  out  1  memory request
mem_we  out  1  write strobe, valid with mem_req
addr_sel  out  1  0=PC, 1=ALU result
ir_we  out  1  load instruction register
mdr_we  out  1  load memory data register
rf_we  out  1  register-file write
pc_we  out  1  PC update
pc_src  out  2  00=PC+4, 01=PC+imm, 10=ALU result
wb_sel  out  2  00=ALU, 01=MDR, 10=PC+4
fault  out  1  sticky fault
fault_code  out  2  00 none, 01 illegal opcode, 10 memory timeout
retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, any state):
  - state=IDLE, retired=0, fault=0, fault_code=00, timeout counter=0.
  - All strobes 0, pc_src=00, wb_sel=00.
- Outputs decode state combinationally; strobes gated by mem_ready are Mealy. State, counters and fault are registered.
- IDLE: all strobes 0. Go to FETCH when run=1.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - mem_req and addr_sel are held until mem_ready. Zero-wait is legal (ready in the same cycle as the request).
  - In the ready cycle: ir_we=1, then go to DECODE.
- DECODE: one cycle, no strobes. Go to EXEC.
- EXEC, priority order:
  1. Illegal opcode (not one of 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111) -> FAULT, fault_code=01.
  2. mem_read|mem_write -> MEM.
  3. branch -> pc_we=1, pc_src=branch_taken?01:00, retire.
  4. opcode 1101111/1100111 or reg_write -> WB.
  5. Otherwise -> pc_we=1, pc_src=00, retire.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=mem_write; held until mem_ready.
  - Ready cycle, load: mdr_we=1, go to WB.
  - Ready cycle, store: pc_we=1, pc_src=00, retire.
- WB: rf_we=1 and pc_we=1 for one cycle, then retire.
  - jal: wb_sel=10, pc_src=01.
  - jalr: wb_sel=10, pc_src=10.
  - load: wb_sel=01, pc_src=00.
  - else: wb_sel=00, pc_src=00.
- Retire: retired+1 in the same edge. Next state is FETCH if run=1, else IDLE. run is only sampled at IDLE and at retire; it never aborts an issued request.
- Timeout:
  - The counter clears on entry to FETCH/MEM and increments each cycle mem_req=1 && mem_ready=0.
  - When it reaches MEM_TIMEOUT-1 with ready still low: next state FAULT, fault_code=10. mem_req drops the following cycle.
  - mem_ready arriving on the same cycle as expiry wins: normal completion.
- mem_ready outside FETCH/MEM is ignored.
- FAULT: all strobes 0, fault=1, fault_code held, retired frozen. Exit only via rst.
- Cycle counts at zero wait:
  - ALU/jal/jalr: 4.
  - branch / non-writing ops: 3.
  - store: 4.
  - load: 5.
  - Each wait state adds 1.

Decomposition:
- Shared package core_ctrl_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT);
  - pc_src_e, wb_sel_e and fault_code_e;
  - RV32I opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR), shared with the decoder.
- One sub-module: mem_timeout_cnt (clear, enable, expire output, parameter MEM_TIMEOUT).

Test Plan:
- Reset and idle: assert rst mid-MEM with run=0 -> state IDLE, all strobes 0, retired=0, and no mem_req while run stays 0.
- R-type add, zero-wait, run=1, opcode=0110011, reg_write=1 -> ir_we cycle 1, rf_we+pc_we cycle 4, wb_sel=00, pc_src=00, retired=1, mem_req back at cycle 5.
- Load with fetch zero-wait and data ready 3 cycles after MEM entry -> addr_sel=1, mem_we=0 held for 3 cycles; mdr_we in the ready cycle; WB with wb_sel=01; 7 cycles total.
- Branch opcode=1100011, branch_taken=1 then 0 -> pc_we in EXEC with pc_src=01 then 00, rf_we never asserted, 3 cycles each; jalr -> wb_sel=10, pc_src=10.
- Timeout, MEM_TIMEOUT=8, store with mem_ready held 0 -> FAULT after 8 request cycles, fault_code=10, mem_req=0 afterwards. Repeat with ready on cycle 8 -> normal retire.
- Illegal opcode 0000000 in EXEC -> fault=1, fault_code=01, retired unchanged; then rst -> IDLE and fault cleared.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared control types and RV32I opcode constants for the multicycle core
// (used by the sequencer and the instruction decoder).
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    FAULT  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'b00,
    PC_IMM   = 2'b01,
    PC_ALU   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MDR = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ILLEGAL = 2'b01,
    FC_TIMEOUT = 2'b10
  } fault_code_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Wait-state counter for the shared memory port; expire flags the last
// permitted cycle of an unanswered request.
module mem_timeout_cnt #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = enable && (cnt == LAST);

endmodule

// File: rtl/multicycle_seq.sv
// Multicycle sequencer for the RV32I core: steps one instruction through
// fetch/decode/exec/mem/writeback and drives datapath strobes and muxes.
module multicycle_seq
  import core_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [6:0]       opcode,
  input  logic             branch,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             reg_write,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             ir_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [1:0]       wb_sel,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] retired
);

  state_e     state;
  state_e     state_nxt;
  logic [1:0] fc_nxt;
  logic       retire;
  logic       to_clear;
  logic       to_enable;
  logic       to_expire;

  // Counter restarts whenever no request is outstanding or one completes,
  // so every FETCH/MEM entry begins from zero.
  assign to_clear  = ((state != FETCH) && (state != MEM)) || mem_ready;
  assign to_enable = mem_req && !mem_ready;

  mem_timeout_cnt #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear),
    .enable (to_enable),
    .expire (to_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      retired    <= '0;
      fault      <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      state <= state_nxt;
      if (retire) begin
        retired <= retired + CNT_W'(1);
      end
      if (state_nxt == FAULT) begin
        fault      <= 1'b1;
        fault_code <= fc_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    fc_nxt    = fault_code;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    ir_we     = 1'b0;
    mdr_we    = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    wb_sel    = WB_ALU;

    case (state)
      IDLE: begin
        if (run) begin
          state_nxt = FETCH;
        end
      end

      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we     = 1'b1;
          state_nxt = DECODE;
        end else if (to_expire) begin
          state_nxt = FAULT;
          fc_nxt    = FC_TIMEOUT;
        end
      end

      DECODE: begin
        state_nxt = EXEC;
      end

      EXEC: begin
        if (!is_legal_opcode(opcode)) begin
          state_nxt = FAULT;
          fc_nxt    = FC_ILLEGAL;
        end else if (mem_read || mem_write) begin
          state_nxt = MEM;
        end else if (branch) begin
          pc_we  = 1'b1;
          pc_src = branch_taken ? PC_IMM : PC_PLUS4;
          retire = 1'b1;
        end else if ((opcode == OP_JAL) || (opcode == OP_JALR) || reg_write) begin
          state_nxt = WB;
        end else begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end

      MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = mem_write;
        if (mem_ready) begin
          if (mem_write) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end else begin
            mdr_we    = 1'b1;
            state_nxt = WB;
          end
        end else if (to_expire) begin
          state_nxt = FAULT;
          fc_nxt    = FC_TIMEOUT;
        end
      end

      WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        retire = 1'b1;
        if (opcode == OP_JAL) begin
          wb_sel = WB_PC4;
          pc_src = PC_IMM;
        end else if (opcode == OP_JALR) begin
          wb_sel = WB_PC4;
          pc_src = PC_ALU;
        end else if (mem_read) begin
          wb_sel = WB_MDR;
        end
      end

      FAULT: begin
        state_nxt = FAULT;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // run is only consulted when an instruction completes
    if (retire) begin
      state_nxt = run ? FETCH : IDLE;
    end
  end

endmodule

// File: tb/tb_multicycle_seq.sv
// Self-checking bench for multicycle_seq: table of instructions with a
// retire scoreboard, plus hand sequences for reset, back-to-back and faults.
module tb_multicycle_seq;

  localparam int MEM_TIMEOUT = 8;
  localparam int CNT_W       = 8;
  localparam int NEVER       = 255;

  logic             clk;
  logic             rst;
  logic             run;
  logic [6:0]       opcode;
  logic             branch;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             branch_taken;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_we;
  logic             mdr_we;
  logic             rf_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic [1:0]       wb_sel;
  logic             fault;
  logic [1:0]       fault_code;
  logic [CNT_W-1:0] retired;

  multicycle_seq #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .opcode       (opcode),
    .branch       (branch),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .addr_sel     (addr_sel),
    .ir_we        (ir_we),
    .mdr_we       (mdr_we),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .wb_sel       (wb_sel),
    .fault        (fault),
    .fault_code   (fault_code),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] opcode;
    bit         br;
    bit         mr;
    bit         mw;
    bit         rw;
    bit         taken;
    int         fwait;
    int         mwait;
    int         cycles;
    int         pc_src;
    int         wb_sel;
    bit         rf;
    bit         mdr;
    int         memc;
  } vec_t;

  vec_t vecs[12];
  vec_t sb[$];

  int n_checks;
  int n_fail;
  int exp_retired;
  int fwait_cur;
  int mwait_cur;
  int req_cycles;

  bit in_instr;
  int cyc;
  int memc;
  bit rf_seen;
  bit mdr_seen;
  bit we_seen;
  int wb_obs;
  int vidx;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: answer the memory port at the falling edge, then observe.
  task automatic tick();
    int w;
    @(negedge clk);
    if (rst || !mem_req) begin
      mem_ready  = 1'b0;
      req_cycles = 0;
    end else begin
      w = addr_sel ? mwait_cur : fwait_cur;
      if (req_cycles >= w) begin
        mem_ready  = 1'b1;
        req_cycles = 0;
      end else begin
        mem_ready  = 1'b0;
        req_cycles++;
      end
    end
    #1;
    if (rst) begin
      in_instr = 1'b0;
    end else begin
      if (!in_instr && mem_req && !addr_sel) begin
        in_instr = 1'b1;
        cyc      = 0;
        memc     = 0;
        rf_seen  = 1'b0;
        mdr_seen = 1'b0;
        we_seen  = 1'b0;
        wb_obs   = 0;
      end
      if (in_instr) begin
        cyc++;
        if (mem_req && addr_sel) memc++;
        if (mem_req && mem_we) we_seen = 1'b1;
        if (mdr_we) mdr_seen = 1'b1;
        if (rf_we) begin
          rf_seen = 1'b1;
          wb_obs  = int'(wb_sel);
        end
        if (ir_we && sb.size() > 0)
          chk($sformatf("v%0d ir_we_cycle", vidx), cyc, sb[0].fwait + 1);
        if (pc_we) begin
          if (sb.size() == 0) begin
            chk("unexpected_retire pc_we", 1, 0);
          end else begin
            vec_t e;
            e = sb.pop_front();
            chk($sformatf("v%0d cycles", vidx), cyc, e.cycles);
            chk($sformatf("v%0d pc_src", vidx), int'(pc_src), e.pc_src);
            chk($sformatf("v%0d rf_we_seen", vidx), int'(rf_seen), int'(e.rf));
            chk($sformatf("v%0d mdr_we_seen", vidx), int'(mdr_seen), int'(e.mdr));
            chk($sformatf("v%0d mem_cycles", vidx), memc, e.memc);
            chk($sformatf("v%0d mem_we_seen", vidx), int'(we_seen), int'(e.mw));
            if (e.rf) chk($sformatf("v%0d wb_sel", vidx), wb_obs, e.wb_sel);
          end
          in_instr = 1'b0;
        end
      end
    end
  endtask

  task automatic set_inputs(input vec_t v);
    opcode       = v.opcode;
    branch       = v.br;
    mem_read     = v.mr;
    mem_write    = v.mw;
    reg_write    = v.rw;
    branch_taken = v.taken;
    fwait_cur    = v.fwait;
    mwait_cur    = v.mwait;
  endtask

  task automatic wait_sb_empty(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      chk({name, " retire_timeout"}, 0, 1);
      sb.delete();
    end
  endtask

  task automatic run_vec(input int idx);
    vidx = idx;
    set_inputs(vecs[idx]);
    sb.push_back(vecs[idx]);
    exp_retired++;
    run = 1'b1;
    tick();
    run = 1'b0;
    wait_sb_empty($sformatf("v%0d", idx));
    tick();
    chk($sformatf("v%0d retired", idx), int'(retired), exp_retired);
    chk($sformatf("v%0d idle_mem_req", idx), int'(mem_req), 0);
  endtask

  task automatic chk_strobes_zero(input string name);
    chk(name, int'({mem_req, mem_we, addr_sel, ir_we, mdr_we, rf_we, pc_we, pc_src, wb_sel}), 0);
  endtask

  initial begin
    int n;
    bit seen;
    vec_t v;

    n_checks = 0; n_fail = 0; exp_retired = 0;
    fwait_cur = 0; mwait_cur = 0; req_cycles = 0;
    in_instr = 1'b0; cyc = 0; memc = 0; vidx = 0;
    rf_seen = 1'b0; mdr_seen = 1'b0; we_seen = 1'b0; wb_obs = 0;
    rst = 1'b1; run = 1'b0; opcode = 7'd0; branch = 1'b0; mem_read = 1'b0;
    mem_write = 1'b0; reg_write = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;

    //           opcode      br mr mw rw tk fw mw     cyc pc wb rf mdr memc
    vecs[0]  = '{7'b0110011, 0, 0, 0, 1, 0, 0, 0,     4,  0, 0, 1, 0,  0};
    vecs[1]  = '{7'b0010011, 0, 0, 0, 1, 0, 0, 0,     4,  0, 0, 1, 0,  0};
    vecs[2]  = '{7'b0000011, 0, 1, 0, 1, 0, 0, 2,     7,  0, 1, 1, 1,  3};
    vecs[3]  = '{7'b0100011, 0, 0, 1, 0, 0, 0, 0,     4,  0, 0, 0, 0,  1};
    vecs[4]  = '{7'b1100011, 1, 0, 0, 0, 1, 0, 0,     3,  1, 0, 0, 0,  0};
    vecs[5]  = '{7'b1100011, 1, 0, 0, 0, 0, 0, 0,     3,  0, 0, 0, 0,  0};
    vecs[6]  = '{7'b1101111, 0, 0, 0, 1, 0, 0, 0,     4,  1, 2, 1, 0,  0};
    vecs[7]  = '{7'b1100111, 0, 0, 0, 1, 0, 0, 0,     4,  2, 2, 1, 0,  0};
    vecs[8]  = '{7'b0110011, 0, 0, 0, 1, 0, 2, 0,     6,  0, 0, 1, 0,  0};
    vecs[9]  = '{7'b0010011, 0, 0, 0, 0, 0, 0, 0,     3,  0, 0, 0, 0,  0};
    vecs[10] = '{7'b0100011, 0, 0, 1, 0, 0, 1, 2,     7,  0, 0, 0, 0,  3};
    vecs[11] = '{7'b0100011, 0, 0, 1, 0, 0, 0, 7,     11, 0, 0, 0, 0,  8};

    // reset state
    tick();
    tick();
    chk_strobes_zero("reset strobes");
    chk("reset retired", int'(retired), 0);
    chk("reset fault", int'({fault, fault_code}), 0);
    rst = 1'b0;
    tick();
    chk("idle no_req", int'(mem_req), 0);

    for (int i = 0; i < 12; i++) run_vec(i);

    // back-to-back R-type with run held high: next fetch right after retire
    vidx = 100;
    set_inputs(vecs[0]);
    sb.push_back(vecs[0]);
    sb.push_back(vecs[0]);
    exp_retired += 2;
    run = 1'b1;
    tick();
    n = 0;
    while (sb.size() == 2 && n < 30) begin
      tick();
      n++;
    end
    chk("b2b first_retire", int'(sb.size()), 1);
    tick();
    chk("b2b mem_req_cycle5", int'(mem_req), 1);
    run = 1'b0;
    wait_sb_empty("b2b");
    tick();
    chk("b2b retired", int'(retired), exp_retired);

    // reset asserted mid-MEM of a load with run low
    vidx = 200;
    v = vecs[2];
    v.mwait = NEVER;
    set_inputs(v);
    run = 1'b1;
    tick();
    run = 1'b0;
    n = 0;
    while (!(mem_req && addr_sel) && n < 20) begin
      tick();
      n++;
    end
    chk("rst_mid_mem reached_mem", int'(mem_req && addr_sel), 1);
    tick();
    rst = 1'b1;
    #1;
    chk_strobes_zero("rst_mid_mem strobes");
    chk("rst_mid_mem retired", int'(retired), 0);
    exp_retired = 0;
    sb.delete();
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (mem_req) seen = 1'b1;
    end
    chk("rst_mid_mem no_req_while_idle", int'(seen), 0);
    chk("rst_mid_mem fault", int'({fault, fault_code}), 0);

    // store timeout: memory never answers
    vidx = 300;
    v = vecs[3];
    v.mwait = NEVER;
    set_inputs(v);
    run = 1'b1;
    tick();
    run = 1'b0;
    n = 0;
    while (!fault && n < 40) begin
      tick();
      n++;
    end
    chk("timeout fault", int'(fault), 1);
    chk("timeout mem_cycles", memc, MEM_TIMEOUT);
    chk("timeout fault_code", int'(fault_code), 2);
    chk("timeout mem_req_after", int'(mem_req), 0);
    chk("timeout retired", int'(retired), exp_retired);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // illegal opcode
    vidx = 400;
    v = vecs[0];
    v.opcode = 7'b0000000;
    set_inputs(v);
    run = 1'b1;
    tick();
    n = 0;
    while (!fault && n < 20) begin
      tick();
      n++;
    end
    chk("illegal fault", int'(fault), 1);
    chk("illegal fault_code", int'(fault_code), 1);
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_req || pc_we || rf_we) seen = 1'b1;
    end
    chk("illegal strobes_in_fault", int'(seen), 0);
    chk("illegal sticky", int'({fault, fault_code}), 5);
    chk("illegal retired", int'(retired), exp_retired);
    run = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("illegal cleared", int'({fault, fault_code}), 0);
    chk_strobes_zero("illegal idle_strobes");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
